instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the max WAIT cycles before a fault (used only with FETCH_TIMEOUT_EN).
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, giving the `instr` value after reset and flush.
REQ-003 SHALL use one clock; reset is synchronous and active-high. Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- pc  input  32  current PC from program counter
- fetch_en  input  1  control unit requests one fetch
- mem_req  output  1  instruction-memory read strobe
- mem_addr  output  32  read address
- mem_rdata  input  32  read data
- mem_rvalid  input  1  read data valid
- instr  output  32  latched instruction
- instr_pc  output  32  PC of latched instruction
- instr_valid  output  1  instruction available to decode
- instr_ready  input  1  decode accepts instruction
- redirect  input  1  branch/jump flush
- redirect_pc  input  32  redirect target
- pc_write  output  1  PC update enable to program counter
- next_pc  output  32  PC update value
- fetch_fault  output  1  sticky timeout fault

Function
REQ-004 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, DRAIN, FAULT.
REQ-005 IDLE: on fetch_en=1 and redirect=0, go to REQ.
REQ-006 REQ: mem_req=1, mem_addr=pc for exactly one cycle; capture pc into instr_pc; go to WAIT. mem_rvalid SHALL be ignored in REQ.
REQ-007 WAIT: mem_req=0. On mem_rvalid=1, latch instr=mem_rdata, drive pc_write=1 and next_pc=instr_pc+4 (mod 2^32, so 0xFFFF_FFFC wraps to 0) combinationally that cycle, then go to HOLD.
REQ-008 HOLD: instr_valid=1; instr and instr_pc SHALL stay stable. On instr_ready=1, go to REQ if fetch_en=1, else IDLE.
REQ-009 Redirect in any state except FAULT SHALL drive pc_write=1 and next_pc=redirect_pc that cycle, and SHALL override any REQ-007 update.
REQ-010 Redirect effect on state:
- IDLE, HOLD: go to IDLE, instr_valid=0, instr=NOP_INSTR.
- REQ, WAIT: go to DRAIN.
- WAIT with mem_rvalid=1 in the same cycle: discard data, go to IDLE.
REQ-011 DRAIN: mem_req=0, instr_valid=0. The first mem_rvalid is discarded with no pc_write, then go to IDLE.
REQ-012 pc_write SHALL be a single-cycle pulse; it SHALL be 0 in all cases not listed above.
REQ-013 Latency: mem_rvalid in WAIT to instr_valid=1 SHALL be 1 cycle. Minimum fetch_en-to-instr_valid SHALL be 3 cycles.

Reset
REQ-014 On reset, the block SHALL set:
- state=IDLE
- instr=NOP_INSTR, instr_pc=0
- instr_valid=0, mem_req=0, pc_write=0, next_pc=0
- fetch_fault=0
REQ-015 Reset mid-fetch SHALL abandon the outstanding read without DRAIN. Any mem_rvalid arriving after reset while in IDLE SHALL be ignored.

Configuration
REQ-016 With FETCH_TIMEOUT_EN defined:
- A counter SHALL clear on WAIT/DRAIN entry and increment each cycle without mem_rvalid.
- On reaching TIMEOUT_CYCLES, the block SHALL set fetch_fault=1 (sticky until reset) and go to FAULT.
- FAULT SHALL ignore fetch_en and redirect, and keep all other outputs at reset values.
REQ-017 Without FETCH_TIMEOUT_EN, fetch_fault SHALL be tied 0, FAULT SHALL be unreachable, and no counter logic SHALL exist.

Structure
REQ-018 Package fetch_pkg SHALL hold:
- the fetch_state_t enum
- XLEN=32
- NOP_INSTR default constant
- PC_STEP=4
REQ-019 Sub-module fetch_timeout_ctr (counter plus terminal-count compare) SHALL be instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-020 Basic fetch: pc=0x1000, fetch_en pulse, mem_rvalid 2 cycles after mem_req with rdata=0x00500093 -> mem_addr=0x1000; instr=0x00500093; instr_pc=0x1000; one pc_write with next_pc=0x1004.
REQ-021 Back-to-back: instr_ready=1 and fetch_en=1 held -> mem_req the cycle after HOLD; addresses 0x1000, 0x1004, 0x1008.
REQ-022 Redirect in WAIT: redirect_pc=0x2000 -> pc_write with next_pc=0x2000; late rdata=0xDEADBEEF discarded; instr_valid stays 0; no second pc_write.
REQ-023 Wrap-around: pc=0xFFFF_FFFC fetch -> next_pc=0x0000_0000.
REQ-024 Reset asserted in WAIT, then mem_rvalid=1 -> no pc_write, instr=0x00000013, instr_valid=0.
REQ-025 With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, no mem_rvalid -> fetch_fault=1 on the 4th WAIT cycle; later fetch_en produces no mem_req until reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN,
    FAULT
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC unit, instruction memory and decode handshakes.
interface instr_fetch_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] pc;
  logic            fetch_en;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rvalid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            pc_write;
  logic [XLEN-1:0] next_pc;
  logic            fetch_fault;

  modport master (
    input  pc, fetch_en, mem_rdata, mem_rvalid, instr_ready, redirect, redirect_pc,
    output mem_req, mem_addr, instr, instr_pc, instr_valid, pc_write, next_pc, fetch_fault
  );

  modport slave (
    output pc, fetch_en, mem_rdata, mem_rvalid, instr_ready, redirect, redirect_pc,
    input  mem_req, mem_addr, instr, instr_pc, instr_valid, pc_write, next_pc, fetch_fault
  );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter; tc flags the last allowed cycle before a fetch fault.
module fetch_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == W'(LIMIT - 1));
endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch FSM. FETCH_TIMEOUT_EN adds a sticky wait-timeout fault.
// States: IDLE idle | REQ read strobe | WAIT await data | HOLD offer to decode | DRAIN drop stale read | FAULT dead
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int              TIMEOUT_CYCLES = 16,
  parameter logic [XLEN-1:0] NOP_INSTR      = NOP_INSTR_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  instr_fetch_if.master bus
);
  fetch_state_t    state, state_next;
  logic [XLEN-1:0] instr_q, instr_d, instr_pc_q, instr_pc_d;
  logic [XLEN-1:0] mem_addr, next_pc;
  logic            mem_req, instr_valid, pc_write;
  logic            timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  logic in_wait, ctr_clear, ctr_tc;

  assign in_wait   = (state == WAIT) || (state == DRAIN);
  assign ctr_clear = !in_wait || (state == WAIT && state_next == DRAIN);

  fetch_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (ctr_clear),
    .en    (in_wait && !bus.mem_rvalid),
    .tc    (ctr_tc)
  );

  assign timeout_hit     = ctr_tc && in_wait && !bus.mem_rvalid && !bus.redirect;
  assign bus.fetch_fault = (state == FAULT) || timeout_hit;
`else
  logic unused_timeout;
  assign unused_timeout  = ^TIMEOUT_CYCLES;
  assign timeout_hit     = 1'b0;
  assign bus.fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= '0;
    end else begin
      state      <= state_next;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_next  = state;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    mem_req     = 1'b0;
    mem_addr    = '0;
    instr_valid = 1'b0;
    pc_write    = 1'b0;
    next_pc     = '0;

    // A redirect always wins the PC update, including over a same-cycle return.
    if (bus.redirect && state != FAULT) begin
      pc_write = 1'b1;
      next_pc  = bus.redirect_pc;
    end

    unique case (state)
      IDLE: begin
        if (bus.redirect)      instr_d = NOP_INSTR;
        else if (bus.fetch_en) state_next = REQ;
      end
      REQ: begin
        mem_req    = 1'b1;
        mem_addr   = bus.pc;
        instr_pc_d = bus.pc;
        state_next = bus.redirect ? DRAIN : WAIT;
      end
      WAIT: begin
        if (bus.redirect) begin
          state_next = bus.mem_rvalid ? IDLE : DRAIN;
        end else if (bus.mem_rvalid) begin
          instr_d    = bus.mem_rdata;
          pc_write   = 1'b1;
          next_pc    = instr_pc_q + PC_STEP;
          state_next = HOLD;
        end else if (timeout_hit) begin
          instr_d    = NOP_INSTR;
          instr_pc_d = '0;
          state_next = FAULT;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (bus.redirect) begin
          instr_d    = NOP_INSTR;
          state_next = IDLE;
        end else if (bus.instr_ready) begin
          state_next = bus.fetch_en ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (bus.mem_rvalid) begin
          state_next = IDLE;
        end else if (timeout_hit) begin
          instr_d    = NOP_INSTR;
          instr_pc_d = '0;
          state_next = FAULT;
        end
      end
      FAULT: begin
        instr_d    = NOP_INSTR;
        instr_pc_d = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = mem_addr;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid;
  assign bus.pc_write    = pc_write;
  assign bus.next_pc     = next_pc;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch; the bench plays the program counter and instruction memory.
module tb_instr_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch #(.TIMEOUT_CYCLES(4), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  int pw_count = 0;
  logic [31:0] pc_q = '0;

  // One clock; the PC model takes any pc_write seen just before the edge.
  task automatic tick();
    logic pw;
    logic [31:0] np;
    #1;
    pw = bus.pc_write;
    np = bus.next_pc;
    @(posedge clk);
    #1;
    if (pw) begin
      pc_q = np;
      pw_count++;
    end
    bus.pc = pc_q;
  endtask

  task automatic clear_inputs();
    bus.fetch_en    = 1'b0;
    bus.mem_rdata   = '0;
    bus.mem_rvalid  = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.pc          = pc_q;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_fetch(input logic [31:0] addr);
    pc_q = addr;
    bus.pc = addr;
    bus.fetch_en = 1'b1;
    tick();
    bus.fetch_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.instr !== NOP) $display("FAIL reset_instr: got %h want %h", bus.instr, NOP); else passed++;
    checks++; if (bus.instr_pc !== 32'h0) $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); else passed++;
    checks++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); else passed++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); else passed++;
    checks++; if (bus.pc_write !== 1'b0) $display("FAIL reset_pc_write: got %b want 0", bus.pc_write); else passed++;
    checks++; if (bus.next_pc !== 32'h0) $display("FAIL reset_next_pc: got %h want 0", bus.next_pc); else passed++;
    checks++; if (bus.fetch_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", bus.fetch_fault); else passed++;
  endtask

  task automatic test_basic();
    int base;
    do_reset();
    base = pw_count;
    start_fetch(32'h1000);
    #1;
    checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h1000})
      $display("FAIL basic_req: got req=%b addr=%h want req=1 addr=1000", bus.mem_req, bus.mem_addr); else passed++;
    tick();
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL basic_req_single: got %b want 0", bus.mem_req); else passed++;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0050_0093;
    #1;
    checks++; if ({bus.pc_write, bus.next_pc} !== {1'b1, 32'h1004})
      $display("FAIL basic_pc_write: got pw=%b next=%h want pw=1 next=1004", bus.pc_write, bus.next_pc); else passed++;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    #1;
    checks++; if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 32'h0050_0093, 32'h1000})
      $display("FAIL basic_instr: got v=%b i=%h pc=%h want v=1 i=00500093 pc=1000", bus.instr_valid, bus.instr, bus.instr_pc); else passed++;
    checks++; if (pw_count - base !== 1) $display("FAIL basic_pw_count: got %0d want 1", pw_count - base); else passed++;
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    #1;
    checks++; if (bus.instr_valid !== 1'b0) $display("FAIL basic_accept: got %b want 0", bus.instr_valid); else passed++;
  endtask

  task automatic test_random_fetches();
    logic [31:0] addr, data, exp_next;
    int lat, hold, base;
    bit noise;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      addr  = $urandom & 32'hFFFF_FFFC;
      data  = $urandom;
      lat   = $urandom_range(0, 3);
      hold  = $urandom_range(0, 3);
      noise = 1'($urandom_range(0, 1));
      exp_next = addr + 32'd4;
      base = pw_count;
      start_fetch(addr);
      if (noise) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = ~data;
      end
      #1;
      checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, addr})
        $display("FAIL rand_req[%0d]: got req=%b addr=%h want addr=%h", n, bus.mem_req, bus.mem_addr, addr); else passed++;
      tick();
      bus.mem_rvalid = 1'b0;
      repeat (lat) tick();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = data;
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      #1;
      checks++; if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, data, addr})
        $display("FAIL rand_instr[%0d]: got v=%b i=%h pc=%h want i=%h pc=%h", n, bus.instr_valid, bus.instr, bus.instr_pc, data, addr); else passed++;
      checks++; if (pc_q !== exp_next || pw_count - base !== 1)
        $display("FAIL rand_next_pc[%0d]: got pc=%h writes=%0d want pc=%h writes=1", n, pc_q, pw_count - base, exp_next); else passed++;
      for (int h = 0; h < hold; h++) begin
        tick();
        checks++; if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, data, addr})
          $display("FAIL rand_hold[%0d]: got v=%b i=%h pc=%h want i=%h pc=%h", n, bus.instr_valid, bus.instr, bus.instr_pc, data, addr); else passed++;
      end
      bus.instr_ready = 1'b1;
      tick();
      bus.instr_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    int cyc [3];
    int nreq;
    logic prev;
    do_reset();
    pc_q = 32'h1000;
    bus.pc = pc_q;
    bus.fetch_en = 1'b1;
    bus.instr_ready = 1'b1;
    nreq = 0;
    prev = 1'b0;
    for (int c = 0; c < 40 && nreq < 3; c++) begin
      bus.mem_rvalid = prev;
      bus.mem_rdata  = $urandom;
      #1;
      if (bus.mem_req) begin
        addrs[nreq] = bus.mem_addr;
        cyc[nreq]   = c;
        nreq++;
        if (nreq == 3) bus.fetch_en = 1'b0;
      end
      prev = bus.mem_req;
      tick();
    end
    bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    tick();
    bus.instr_ready = 1'b0;
    checks++; if (nreq !== 3) $display("FAIL b2b_count: got %0d requests want 3", nreq); else passed++;
    for (int k = 0; k < nreq; k++) begin
      checks++; if (addrs[k] !== 32'h1000 + 32'(4 * k))
        $display("FAIL b2b_addr[%0d]: got %h want %h", k, addrs[k], 32'h1000 + 32'(4 * k)); else passed++;
      if (k > 0) begin
        checks++; if (cyc[k] - cyc[k-1] !== 3)
          $display("FAIL b2b_spacing[%0d]: got %0d cycles want 3", k, cyc[k] - cyc[k-1]); else passed++;
      end
    end
    checks++; if (pc_q !== 32'h100C) $display("FAIL b2b_final_pc: got %h want 100c", pc_q); else passed++;
  endtask

  task automatic test_redirect();
    int base;
    // redirect while waiting, late data must be dropped
    do_reset();
    start_fetch(32'h3000);
    tick();
    base = pw_count;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h2000;
    #1;
    checks++; if ({bus.pc_write, bus.next_pc} !== {1'b1, 32'h2000})
      $display("FAIL redir_wait_pw: got pw=%b next=%h want pw=1 next=2000", bus.pc_write, bus.next_pc); else passed++;
    tick();
    bus.redirect = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.pc_write !== 1'b0) $display("FAIL redir_drain_pw: got %b want 0", bus.pc_write); else passed++;
    tick();
    bus.mem_rvalid = 1'b0;
    tick();
    checks++; if (bus.instr_valid !== 1'b0 || bus.instr === 32'hDEAD_BEEF)
      $display("FAIL redir_discard: got v=%b i=%h want v=0 and data dropped", bus.instr_valid, bus.instr); else passed++;
    checks++; if (pw_count - base !== 1 || pc_q !== 32'h2000)
      $display("FAIL redir_pc: got writes=%0d pc=%h want writes=1 pc=2000", pw_count - base, pc_q); else passed++;
    start_fetch(pc_q);
    #1;
    checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h2000})
      $display("FAIL redir_refetch: got req=%b addr=%h want req=1 addr=2000", bus.mem_req, bus.mem_addr); else passed++;

    // redirect and data in the same WAIT cycle: redirect target wins, back to IDLE
    do_reset();
    start_fetch(32'h4000);
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h5000;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = $urandom;
    #1;
    checks++; if ({bus.pc_write, bus.next_pc} !== {1'b1, 32'h5000})
      $display("FAIL redir_same_cycle: got pw=%b next=%h want pw=1 next=5000", bus.pc_write, bus.next_pc); else passed++;
    tick();
    clear_inputs();
    start_fetch(pc_q);
    #1;
    checks++; if ({bus.mem_req, bus.mem_addr, bus.instr_valid} !== {1'b1, 32'h5000, 1'b0})
      $display("FAIL redir_same_idle: got req=%b addr=%h v=%b want req=1 addr=5000 v=0", bus.mem_req, bus.mem_addr, bus.instr_valid); else passed++;

    // redirect while holding an instruction flushes it
    do_reset();
    start_fetch(32'h0000_8000);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h6000;
    #1;
    checks++; if ({bus.pc_write, bus.next_pc} !== {1'b1, 32'h6000})
      $display("FAIL redir_hold_pw: got pw=%b next=%h want pw=1 next=6000", bus.pc_write, bus.next_pc); else passed++;
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++; if ({bus.instr_valid, bus.instr} !== {1'b0, NOP})
      $display("FAIL redir_hold_flush: got v=%b i=%h want v=0 i=%h", bus.instr_valid, bus.instr, NOP); else passed++;

    // redirect during the request cycle drains the outstanding read
    do_reset();
    start_fetch(32'h9000);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h7000;
    tick();
    bus.redirect = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = $urandom;
    #1;
    checks++; if (bus.pc_write !== 1'b0) $display("FAIL redir_req_drain_pw: got %b want 0", bus.pc_write); else passed++;
    tick();
    bus.mem_rvalid = 1'b0;
    start_fetch(pc_q);
    #1;
    checks++; if ({bus.mem_req, bus.mem_addr, bus.instr_valid} !== {1'b1, 32'h7000, 1'b0})
      $display("FAIL redir_req_refetch: got req=%b addr=%h v=%b want req=1 addr=7000 v=0", bus.mem_req, bus.mem_addr, bus.instr_valid); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] addr, exp_next;
    do_reset();
    addr = 32'hFFFF_FFFC;
    exp_next = addr + 32'd4;
    start_fetch(addr);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = $urandom;
    #1;
    checks++; if ({bus.pc_write, bus.next_pc} !== {1'b1, exp_next})
      $display("FAIL wrap_next_pc: got pw=%b next=%h want pw=1 next=%h", bus.pc_write, bus.next_pc, exp_next); else passed++;
    tick();
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    start_fetch(32'h0000_A000);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = $urandom;
    #1;
    checks++; if (bus.pc_write !== 1'b0) $display("FAIL rstmid_pw: got %b want 0", bus.pc_write); else passed++;
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    checks++; if ({bus.instr, bus.instr_valid, bus.mem_req} !== {NOP, 1'b0, 1'b0})
      $display("FAIL rstmid_state: got i=%h v=%b req=%b want i=%h v=0 req=0", bus.instr, bus.instr_valid, bus.mem_req, NOP); else passed++;
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    start_fetch(32'h0000_B000);
    tick();
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++; if (bus.fetch_fault !== 1'b0) $display("FAIL timeout_early[%0d]: got %b want 0", k, bus.fetch_fault); else passed++;
      tick();
    end
    #1;
    checks++; if (bus.fetch_fault !== 1'b1) $display("FAIL timeout_fire: got %b want 1", bus.fetch_fault); else passed++;
    tick();
    bus.fetch_en = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h1111_0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({bus.fetch_fault, bus.mem_req, bus.pc_write, bus.instr_valid, bus.instr} !== {1'b1, 1'b0, 1'b0, 1'b0, NOP})
        $display("FAIL timeout_sticky[%0d]: got f=%b req=%b pw=%b v=%b i=%h", k, bus.fetch_fault, bus.mem_req, bus.pc_write, bus.instr_valid, bus.instr); else passed++;
      tick();
    end
    do_reset();
    #1;
    checks++; if (bus.fetch_fault !== 1'b0) $display("FAIL timeout_reset: got %b want 0", bus.fetch_fault); else passed++;
  endtask
`else
  task automatic test_timeout();
    do_reset();
    start_fetch(32'h0000_B000);
    repeat (20) tick();
    #1;
    checks++; if ({bus.fetch_fault, bus.instr_valid} !== 2'b00)
      $display("FAIL no_timeout: got f=%b v=%b want 0 0", bus.fetch_fault, bus.instr_valid); else passed++;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    bus.mem_rvalid = 1'b0;
    #1;
    checks++; if ({bus.instr_valid, bus.instr} !== {1'b1, 32'h0BAD_F00D})
      $display("FAIL no_timeout_late_data: got v=%b i=%h want v=1 i=0badf00d", bus.instr_valid, bus.instr); else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_random_fetches();
    test_back_to_back();
    test_redirect();
    test_wrap();
    test_reset_mid_fetch();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
